// File: rtl/execute_stage_mc_if.sv
// E-stage inputs and EX/MEM outputs of execute_stage_mc, bundled as one interface.
// master drives the E-stage side (decode/hazard unit); slave is the execute stage.
interface execute_stage_mc_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              ValidE;
  logic              FlushE;
  logic              StallM;
  logic [XLEN-1:0]   RD1E;
  logic [XLEN-1:0]   RD2E;
  logic [XLEN-1:0]   PCE;
  logic [XLEN-1:0]   PCPlus4E;
  logic [XLEN-1:0]   ImmExtE;
  logic [XLEN-1:0]   ResultW;
  logic [REG_AW-1:0] RdE;
  logic              RegWriteE;
  logic              MemWriteE;
  logic              ALUSrcE;
  logic              JumpE;
  logic              BranchE;
  logic              JalrE;
  logic [1:0]        ResultSrcE;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic [2:0]        BranchCondE;
  logic [3:0]        ALUControlE;

  logic [XLEN-1:0]   ALUResultM;
  logic [XLEN-1:0]   WriteDataM;
  logic [XLEN-1:0]   PCPlus4M;
  logic [REG_AW-1:0] RdM;
  logic              RegWriteM;
  logic              MemWriteM;
  logic              ValidM;
  logic [1:0]        ResultSrcM;
  logic [XLEN-1:0]   PCTargetE;
  logic              PCSrcE;
  logic              BusyE;

  modport master (
    output ValidE, FlushE, StallM, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, ResultW, RdE,
           RegWriteE, MemWriteE, ALUSrcE, JumpE, BranchE, JalrE, ResultSrcE,
           ForwardAE, ForwardBE, BranchCondE, ALUControlE,
    input  ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ValidM,
           ResultSrcM, PCTargetE, PCSrcE, BusyE
  );

  modport slave (
    input  ValidE, FlushE, StallM, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, ResultW, RdE,
           RegWriteE, MemWriteE, ALUSrcE, JumpE, BranchE, JalrE, ResultSrcE,
           ForwardAE, ForwardBE, BranchCondE, ALUControlE,
    output ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ValidM,
           ResultSrcM, PCTargetE, PCSrcE, BusyE
  );
endinterface

// File: rtl/execute_stage_mc.sv
// RV32-style execute stage with EX/MEM register; iterative multiplier built only with EXEC_MUL_EN.
// Multiplier FSM:  state | meaning
//   IDLE | no multiply in flight; a valid mul/mulhu starts one (BusyE=1)
//   MUL  | retiring MUL_BITS multiplier bits per cycle (BusyE=1)
//   DONE | product ready, handed to EX/MEM on the next non-stalled edge
module execute_stage_mc #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int MUL_BITS = 1
) (
  input  logic clk,
  input  logic rst,
  execute_stage_mc_if.slave ex
);
  localparam int SHW = $clog2(XLEN);

  if ((XLEN % MUL_BITS) != 0) begin : gBadMulBits
    $error("MUL_BITS must divide XLEN");
  end

  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic [XLEN-1:0] writeData;
  logic [XLEN-1:0] aluResult;
  logic [XLEN-1:0] exResult;
  logic [XLEN-1:0] jalrSum;
  logic [SHW-1:0]  shamt;
  logic            takeCond;
  logic            busy;

  always_comb begin
    case (ex.ForwardAE)
      2'b01:   srcA = ex.ResultW;
      2'b10:   srcA = ex.ALUResultM;
      default: srcA = ex.RD1E;
    endcase
    case (ex.ForwardBE)
      2'b01:   writeData = ex.ResultW;
      2'b10:   writeData = ex.ALUResultM;
      default: writeData = ex.RD2E;
    endcase
    srcB = ex.ALUSrcE ? ex.ImmExtE : writeData;
  end

  always_comb begin
    aluResult = '0;
    shamt     = srcB[SHW-1:0];
    case (ex.ALUControlE)
      4'h0: aluResult = srcA + srcB;
      4'h1: aluResult = srcA - srcB;
      4'h2: aluResult = srcA & srcB;
      4'h3: aluResult = srcA | srcB;
      4'h4: aluResult = srcA ^ srcB;
      4'h5: aluResult = {{(XLEN-1){1'b0}}, $signed(srcA) < $signed(srcB)};
      4'h6: aluResult = {{(XLEN-1){1'b0}}, srcA < srcB};
      4'h7: aluResult = srcA << shamt;
      4'h8: aluResult = srcA >> shamt;
      4'h9: aluResult = $signed(srcA) >>> shamt;
      default: aluResult = '0;
    endcase
  end

  always_comb begin
    case (ex.BranchCondE)
      3'b000:  takeCond = (srcA == writeData);
      3'b001:  takeCond = (srcA != writeData);
      3'b100:  takeCond = ($signed(srcA) < $signed(writeData));
      3'b101:  takeCond = ($signed(srcA) >= $signed(writeData));
      3'b110:  takeCond = (srcA < writeData);
      3'b111:  takeCond = (srcA >= writeData);
      default: takeCond = 1'b0;
    endcase
  end

  assign jalrSum      = srcA + ex.ImmExtE;
  assign ex.PCTargetE = ex.JalrE ? {jalrSum[XLEN-1:1], 1'b0} : ex.PCE + ex.ImmExtE;
  assign ex.PCSrcE    = ex.ValidE & ~busy & (ex.JumpE | (ex.BranchE & takeCond));
  assign ex.BusyE     = busy;

`ifdef EXEC_MUL_EN
  localparam int N  = XLEN / MUL_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} mulState_t;

  mulState_t         state;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] mcand;
  logic [2*XLEN-1:0] partial;
  logic [XLEN-1:0]   mplier;
  logic [XLEN-1:0]   mulResult;
  logic              mulHigh;
  logic              isMul;
  logic              startMul;

  assign isMul     = (ex.ALUControlE == 4'hA) | (ex.ALUControlE == 4'hB);
  assign startMul  = (state == IDLE) & ex.ValidE & isMul & ~ex.FlushE;
  // Gated by rst so an in-flight multiply reads as idle the moment reset asserts.
  assign busy      = rst & ((state == MUL) | startMul);
  assign partial   = mcand * {{(2*XLEN-MUL_BITS){1'b0}}, mplier[MUL_BITS-1:0]};
  assign mulResult = mulHigh ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
  assign exResult  = (state == DONE) ? mulResult : aluResult;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      mulHigh <= 1'b0;
    end else if (ex.FlushE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (startMul) begin
          mcand   <= {{XLEN{1'b0}}, srcA};
          mplier  <= srcB;
          acc     <= '0;
          count   <= CW'(N - 1);
          mulHigh <= ex.ALUControlE[0];
          state   <= MUL;
        end
        MUL: begin
          acc    <= acc + partial;
          mcand  <= mcand << MUL_BITS;
          mplier <= mplier >> MUL_BITS;
          if (count == '0) state <= DONE;
          else             count <= count - 1'b1;
        end
        DONE: if (!ex.StallM) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign busy     = 1'b0;
  assign exResult = aluResult;
`endif

  // Bubbles clear only the qualifying control bits; data fields keep their old values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex.ALUResultM <= '0;
      ex.WriteDataM <= '0;
      ex.PCPlus4M   <= '0;
      ex.RdM        <= '0;
      ex.RegWriteM  <= 1'b0;
      ex.MemWriteM  <= 1'b0;
      ex.ValidM     <= 1'b0;
      ex.ResultSrcM <= '0;
    end else if (!ex.StallM) begin
      if (ex.FlushE | ~ex.ValidE | busy) begin
        ex.ValidM    <= 1'b0;
        ex.RegWriteM <= 1'b0;
        ex.MemWriteM <= 1'b0;
      end else begin
        ex.ALUResultM <= exResult;
        ex.WriteDataM <= writeData;
        ex.PCPlus4M   <= ex.PCPlus4E;
        ex.RdM        <= ex.RdE;
        ex.RegWriteM  <= ex.RegWriteE;
        ex.MemWriteM  <= ex.MemWriteE;
        ex.ValidM     <= 1'b1;
        ex.ResultSrcM <= ex.ResultSrcE;
      end
    end
  end
endmodule

// File: tb/tb_execute_stage_mc.sv
// Directed bench for execute_stage_mc; multiply scenarios run only when EXEC_MUL_EN is defined.
module tb_execute_stage_mc;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nCmp = 0;
  int   nBad = 0;

  execute_stage_mc_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

  execute_stage_mc #(.XLEN(XLEN), .REG_AW(REG_AW), .MUL_BITS(1)) dut (
    .clk (clk),
    .rst (rst),
    .ex  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.ValidE = 0; bus.FlushE = 0; bus.StallM = 0;
    bus.RD1E = '0; bus.RD2E = '0; bus.PCE = '0; bus.PCPlus4E = '0;
    bus.ImmExtE = '0; bus.ResultW = '0; bus.RdE = '0;
    bus.RegWriteE = 0; bus.MemWriteE = 0; bus.ALUSrcE = 0;
    bus.JumpE = 0; bus.BranchE = 0; bus.JalrE = 0;
    bus.ResultSrcE = '0; bus.ForwardAE = '0; bus.ForwardBE = '0;
    bus.BranchCondE = '0; bus.ALUControlE = '0;
  endtask

  task automatic setAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic useImm, input logic [31:0] imm);
    clearInputs();
    bus.ValidE = 1; bus.RegWriteE = 1; bus.RdE = 5'd7;
    bus.ALUControlE = op; bus.RD1E = a; bus.RD2E = b;
    bus.ALUSrcE = useImm; bus.ImmExtE = imm;
  endtask

  task automatic test_reset();
    clearInputs();
    #2;
    nCmp++; if (bus.ValidM !== 1'b0) begin nBad++; $display("FAIL reset_validm got %h want 0", bus.ValidM); end
    nCmp++; if (bus.ALUResultM !== 32'h0) begin nBad++; $display("FAIL reset_alu got %h want 0", bus.ALUResultM); end
    nCmp++; if (bus.RegWriteM !== 1'b0 || bus.RdM !== 5'd0) begin nBad++; $display("FAIL reset_ctrl got %h/%h want 0/0", bus.RegWriteM, bus.RdM); end
    nCmp++; if (bus.BusyE !== 1'b0) begin nBad++; $display("FAIL reset_busy got %h want 0", bus.BusyE); end
    step(); step();
    rst = 1;
    setAlu(4'h0, 32'd20, 32'd22, 0, 0);
    step();
    nCmp++; if (bus.ALUResultM !== 32'd42 || bus.ValidM !== 1'b1) begin nBad++; $display("FAIL reset_first_add got %h/%h want 0000002a/1", bus.ALUResultM, bus.ValidM); end
`ifdef EXEC_MUL_EN
    setAlu(4'hA, 32'h0001_0000, 32'h0003_0000, 0, 0);
    step(); step(); step();
`else
    setAlu(4'h0, 32'd1, 32'd2, 0, 0);
`endif
    rst = 0;
    #1;
    nCmp++; if (bus.ALUResultM !== 32'h0 || bus.ValidM !== 1'b0 || bus.BusyE !== 1'b0) begin nBad++; $display("FAIL reset_midop got alu=%h v=%h busy=%h want 0/0/0", bus.ALUResultM, bus.ValidM, bus.BusyE); end
    clearInputs();
    step();
    rst = 1;
    setAlu(4'h0, 32'd5, 32'd6, 0, 0);
    step();
    nCmp++; if (bus.ALUResultM !== 32'd11 || bus.ValidM !== 1'b1) begin nBad++; $display("FAIL reset_after_add got %h/%h want 0000000b/1", bus.ALUResultM, bus.ValidM); end
  endtask

  task automatic test_alu();
    logic [3:0]  ops  [12];
    logic [31:0] bs   [12];
    logic [31:0] exps [12];
    ops  = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'h7, 4'hC};
    bs   = '{32'h4, 32'h4, 32'h4, 32'h4, 32'h4, 32'h4, 32'h4, 32'h4, 32'h4, 32'h4, 32'h24, 32'h4};
    exps = '{32'h8000_0014, 32'h8000_000C, 32'h0, 32'h8000_0014, 32'h8000_0014, 32'h1,
             32'h0, 32'h0000_0100, 32'h0800_0001, 32'hF800_0001, 32'h0000_0100, 32'h0};
    for (int i = 0; i < 12; i++) begin
      setAlu(ops[i], 32'h8000_0010, bs[i], 0, 0);
      step();
      nCmp++;
      if (bus.ALUResultM !== exps[i] || bus.RdM !== 5'd7 || bus.RegWriteM !== 1'b1) begin
        nBad++; $display("FAIL alu_op%0h got %h rd=%0d want %h rd=7", ops[i], bus.ALUResultM, bus.RdM, exps[i]);
      end
    end
  endtask

  task automatic test_forward();
    setAlu(4'h0, 32'd3, 32'd0, 1, 32'd4);
    step();
    nCmp++; if (bus.ALUResultM !== 32'd7) begin nBad++; $display("FAIL fwd_setup got %h want 7", bus.ALUResultM); end
    setAlu(4'h0, 32'd5, 32'd0, 1, 32'd3);
    bus.ForwardAE = 2'b10;
    step();
    nCmp++; if (bus.ALUResultM !== 32'd10) begin nBad++; $display("FAIL fwd_aluresultm got %h want a", bus.ALUResultM); end
    setAlu(4'h0, 32'd1, 32'd100, 0, 0);
    bus.ForwardBE = 2'b01; bus.ResultW = 32'd50; bus.PCPlus4E = 32'h204; bus.ResultSrcE = 2'd2;
    step();
    nCmp++; if (bus.ALUResultM !== 32'd51 || bus.WriteDataM !== 32'd50) begin nBad++; $display("FAIL fwd_resultw got %h/%h want 33/32", bus.ALUResultM, bus.WriteDataM); end
    nCmp++; if (bus.PCPlus4M !== 32'h204 || bus.ResultSrcM !== 2'd2) begin nBad++; $display("FAIL fwd_passthru got %h/%h want 204/2", bus.PCPlus4M, bus.ResultSrcM); end
    setAlu(4'h0, 32'd9, 32'd2, 0, 0);
    bus.ForwardAE = 2'b11; bus.ResultW = 32'd1000;
    step();
    nCmp++; if (bus.ALUResultM !== 32'd11) begin nBad++; $display("FAIL fwd_sel11 got %h want b", bus.ALUResultM); end
  endtask

  task automatic test_branch();
    logic [2:0] conds [7];
    logic       takes [7];
    conds = '{3'b100, 3'b110, 3'b000, 3'b001, 3'b101, 3'b111, 3'b010};
    takes = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    clearInputs();
    bus.ValidE = 1; bus.PCE = 32'h100; bus.ImmExtE = 32'h20;
    bus.RD1E = 32'hFFFF_FFFF; bus.RD2E = 32'd1; bus.BranchE = 1;
    for (int i = 0; i < 7; i++) begin
      bus.BranchCondE = conds[i];
      #1;
      nCmp++; if (bus.PCSrcE !== takes[i]) begin nBad++; $display("FAIL branch_cond%b got %b want %b", conds[i], bus.PCSrcE, takes[i]); end
    end
    nCmp++; if (bus.PCTargetE !== 32'h120) begin nBad++; $display("FAIL branch_target got %h want 00000120", bus.PCTargetE); end
    bus.BranchE = 0; bus.JalrE = 1; bus.JumpE = 1; bus.RD1E = 32'h1001;
    #1;
    nCmp++; if (bus.PCTargetE !== 32'h1020 || bus.PCSrcE !== 1'b1) begin nBad++; $display("FAIL jalr got %h/%b want 00001020/1", bus.PCTargetE, bus.PCSrcE); end
    bus.ValidE = 0;
    #1;
    nCmp++; if (bus.PCSrcE !== 1'b0) begin nBad++; $display("FAIL jump_invalid got %b want 0", bus.PCSrcE); end
  endtask

  task automatic test_flush_stall();
    setAlu(4'h0, 32'd2, 32'd2, 0, 0);
    step();
    nCmp++; if (bus.ALUResultM !== 32'd4 || bus.ValidM !== 1'b1) begin nBad++; $display("FAIL fs_load got %h/%h want 4/1", bus.ALUResultM, bus.ValidM); end
    setAlu(4'h0, 32'd9, 32'd9, 0, 0);
    bus.StallM = 1;
    step();
    nCmp++; if (bus.ALUResultM !== 32'd4 || bus.ValidM !== 1'b1) begin nBad++; $display("FAIL fs_stall_hold got %h/%h want 4/1", bus.ALUResultM, bus.ValidM); end
    bus.StallM = 0; bus.FlushE = 1;
    step();
    nCmp++; if (bus.ValidM !== 1'b0 || bus.RegWriteM !== 1'b0) begin nBad++; $display("FAIL fs_flush got %h/%h want 0/0", bus.ValidM, bus.RegWriteM); end
    setAlu(4'h0, 32'd3, 32'd3, 0, 0);
    step();
    bus.ValidE = 0;
    step();
    nCmp++; if (bus.ValidM !== 1'b0) begin nBad++; $display("FAIL fs_invalid got %h want 0", bus.ValidM); end
    setAlu(4'h0, 32'd3, 32'd3, 0, 0);
    step();
    bus.StallM = 1; bus.FlushE = 1;
    step();
    nCmp++; if (bus.ALUResultM !== 32'd6 || bus.ValidM !== 1'b1) begin nBad++; $display("FAIL fs_stall_flush got %h/%h want 6/1", bus.ALUResultM, bus.ValidM); end
    setAlu(4'h0, 32'd2, 32'd2, 0, 0);
    step();
  endtask

`ifdef EXEC_MUL_EN
  task automatic test_multiply();
    logic [3:0]  ops  [2];
    logic [31:0] exps [2];
    int busyCnt;
    int guard;
    int validLeak;
    ops  = '{4'hA, 4'hB};
    exps = '{32'h0, 32'h3};
    for (int k = 0; k < 2; k++) begin
      setAlu(ops[k], 32'h0001_0000, 32'h0003_0000, 0, 0);
      #1;
      busyCnt = 0; guard = 0; validLeak = 0;
      while (bus.BusyE === 1'b1 && guard < 200) begin
        busyCnt++;
        if (busyCnt > 1 && bus.ValidM !== 1'b0) validLeak++;
        step();
        guard++;
      end
      nCmp++; if (busyCnt !== 33) begin nBad++; $display("FAIL mul%0h_busy_cycles got %0d want 33", ops[k], busyCnt); end
      nCmp++; if (validLeak !== 0) begin nBad++; $display("FAIL mul%0h_bubbles got %0d valid cycles want 0", ops[k], validLeak); end
      step();
      nCmp++; if (bus.ALUResultM !== exps[k] || bus.ValidM !== 1'b1) begin nBad++; $display("FAIL mul%0h_result got %h/%h want %h/1", ops[k], bus.ALUResultM, bus.ValidM, exps[k]); end
      clearInputs();
      step();
    end
  endtask

  task automatic test_mul_flush();
    setAlu(4'hA, 32'h0001_0000, 32'h0003_0000, 0, 0);
    step();
    repeat (9) step();
    bus.FlushE = 1;
    step();
    nCmp++; if (bus.BusyE !== 1'b0 || bus.ValidM !== 1'b0) begin nBad++; $display("FAIL mul_flush got busy=%h v=%h want 0/0", bus.BusyE, bus.ValidM); end
    setAlu(4'h0, 32'd2, 32'd2, 0, 0);
    step();
    nCmp++; if (bus.ALUResultM !== 32'd4 || bus.ValidM !== 1'b1) begin nBad++; $display("FAIL mul_flush_add got %h/%h want 4/1", bus.ALUResultM, bus.ValidM); end
  endtask

  task automatic test_mul_stall_done();
    int guard;
    int bad;
    setAlu(4'hB, 32'h0001_0000, 32'h0003_0000, 0, 0);
    #1;
    guard = 0;
    while (bus.BusyE === 1'b1 && guard < 200) begin step(); guard++; end
    nCmp++; if (guard >= 200) begin nBad++; $display("FAIL mul_stall_wait got timeout want done"); end
    bus.StallM = 1;
    bad = 0;
    repeat (3) begin
      step();
      if (bus.ALUResultM !== 32'd4 || bus.BusyE !== 1'b0) bad++;
    end
    nCmp++; if (bad !== 0) begin nBad++; $display("FAIL mul_stall_hold got %0d bad cycles (alu=%h) want 0", bad, bus.ALUResultM); end
    bus.StallM = 0;
    step();
    nCmp++; if (bus.ALUResultM !== 32'h3 || bus.ValidM !== 1'b1) begin nBad++; $display("FAIL mul_stall_release got %h/%h want 3/1", bus.ALUResultM, bus.ValidM); end
    clearInputs();
    step();
  endtask
`else
  task automatic test_mul_disabled();
    setAlu(4'hB, 32'h0001_0000, 32'h0003_0000, 0, 0);
    #1;
    nCmp++; if (bus.BusyE !== 1'b0) begin nBad++; $display("FAIL nomul_busy got %h want 0", bus.BusyE); end
    step();
    nCmp++; if (bus.ALUResultM !== 32'h0 || bus.ValidM !== 1'b1) begin nBad++; $display("FAIL nomul_result got %h/%h want 0/1", bus.ALUResultM, bus.ValidM); end
    clearInputs();
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_forward();
    test_branch();
    test_flush_stall();
`ifdef EXEC_MUL_EN
    test_mul_flush();
    test_mul_stall_done();
    test_multiply();
`else
    test_mul_disabled();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
